serial_index_sorter: RTL and testbench
======================================

Name: serial_index_sorter

Overview:
- Sequential sort engine that produces the (data, index) permutation stream that `unsort` consumes.
- Accepts NUM_ELEMENTS unsigned samples serially over a valid/ready handshake and tags each sample with its arrival index.
- Sorts the samples in place with an odd-even transposition network, one phase per clock.
- Streams the sorted data out serially, with the original index of each element, so downstream blocks can restore the original order.

Parameters:
- NUM_ELEMENTS, 32, samples per frame; even, >= 2.
- NETWORK_WIDTH, 8, data bits per sample; unsigned.
- INDEX_WIDTH, 5, bits of arrival index; must equal $clog2(NUM_ELEMENTS).
- ASCENDING, 1'b1, 1 = smallest value at output position 0; 0 = largest first.

Ports:
- clk  in  1  system clock; all state on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous abort; returns to IDLE and discards the frame.
- in_valid  in  1  input sample valid.
- in_ready  out  1  engine can accept a sample.
- in_data  in  NETWORK_WIDTH  input sample.
- out_valid  out  1  sorted element valid.
- out_ready  in  1  downstream accepts the element.
- out_data  out  NETWORK_WIDTH  sorted sample.
- out_index  out  INDEX_WIDTH  arrival index of out_data.
- out_last  out  1  marks output position NUM_ELEMENTS-1.
- busy  out  1  high in SORT and DRAIN.

Behaviour:
- Interface (already decided): one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values:
  - State = IDLE; counters = 0.
  - in_ready = 1, out_valid = 0, out_last = 0, busy = 0.
  - out_data and out_index = 0. Buffer contents don't-care.
- Storage: array of NUM_ELEMENTS entries {data, index}.
- State machine IDLE/LOAD -> SORT -> DRAIN -> IDLE. IDLE and LOAD are a single state, LOAD.
  - LOAD: in_ready = 1. On in_valid && in_ready, write entry[wr_cnt] = {in_data, wr_cnt} and increment wr_cnt. Accepting the sample with wr_cnt == NUM_ELEMENTS-1 moves to SORT and clears wr_cnt.
  - SORT: in_ready = 0. One phase per cycle, pass_cnt 0..NUM_ELEMENTS-1.
    - Even pass_cnt compares pairs (0,1), (2,3), …
    - Odd pass_cnt compares pairs (1,2), (3,4), …
    - Swap only when strictly out of order: lower.data > upper.data if ASCENDING, lower.data < upper.data otherwise. Equal values never swap, so the sort is stable and indices stay ascending among equal data.
    - Index travels with its data.
    - After pass NUM_ELEMENTS-1, go to DRAIN with rd_cnt = 0.
  - DRAIN: out_valid = 1; out_data/out_index = entry[rd_cnt]; out_last = (rd_cnt == NUM_ELEMENTS-1).
    - On out_valid && out_ready, increment rd_cnt.
    - The handshake with out_last high returns to LOAD with in_ready = 1 the next cycle.
- Output stability: while out_valid && !out_ready, out_data, out_index and out_last hold stable.
- Latency: out_valid rises exactly NUM_ELEMENTS clock edges after the edge that accepts the last sample. Minimum frame period is 3*NUM_ELEMENTS cycles.
- Flush:
  - A synchronous override of all handshakes that cycle; state goes to LOAD and all counters clear.
  - out_valid drops on the next edge; no partial frame is emitted.
  - flush in LOAD also discards already-loaded samples.
- Reset mid-operation: immediate return to reset values; the buffer is not cleared.
- in_valid outside LOAD is ignored; no error is flagged.
- Comparisons are unsigned at full NETWORK_WIDTH. There is no arithmetic; counters wrap only via explicit clear.

Decomposition:
- Shared package (extends the existing parameters include): NETWORK_WIDTH, INDEX_WIDTH, typedef sort_entry_t {logic [NETWORK_WIDTH-1:0] data; logic [INDEX_WIDTH-1:0] index;}, and the state enum sorter_state_t {S_LOAD, S_SORT, S_DRAIN}.
- One sub-module: compare_swap. It is combinational, takes two sort_entry_t plus an ASCENDING parameter, and outputs an ordered pair. It is instantiated NUM_ELEMENTS/2 times, and a per-phase mux selects even or odd pairing.

Test Plan:
- N=4, inputs 92,35,95,35 -> out_data 35,35,92,95 and out_index 1,3,0,2. out_last only on the 4th element. out_valid rises 4 edges after the last input is accepted.
- N=32, inputs 31..0 descending -> out_data 0..31 and out_index 31..0. Repeat with ASCENDING=0 on inputs 0..31 -> out_data 31..0 and out_index 31..0.
- N=32, all inputs = 5 -> every out_data = 5 and out_index = 0..31 in order (stability).
- N=8, random data with out_ready toggling at 50% -> exactly 8 outputs, each value/index pair appears once, outputs hold stable while stalled, and the next frame loads right after out_last.
- N=8: flush in SORT at pass 3 -> no out_valid, and a following frame 7,6,5,4,3,2,1,0 sorts correctly. rst_n pulsed low mid-DRAIN -> out_valid = 0 and in_ready = 1 asynchronously.
- N=8, in_valid held high during SORT/DRAIN with garbage data -> ignored; the frame output is unchanged.

Source files
------------

// File: rtl/serial_index_sorter_pkg.sv
// Shared types for the serial index sorter: default widths,
// the {data, index} entry and the sequencer state encoding.
package serial_index_sorter_pkg;

  localparam int NETWORK_WIDTH = 8;
  localparam int INDEX_WIDTH   = 5;

  typedef struct packed {
    logic [NETWORK_WIDTH-1:0] data;
    logic [INDEX_WIDTH-1:0]   index;
  } sort_entry_t;

  typedef enum logic [1:0] {
    S_LOAD,
    S_SORT,
    S_DRAIN
  } sorter_state_t;

endpackage

// File: rtl/serial_index_sorter_if.sv
// Sample-in / sorted-out stream bundle: flush, input valid/ready/data,
// output valid/ready/data/index/last and busy status.
interface serial_index_sorter_if #(
  parameter int NETWORK_WIDTH = serial_index_sorter_pkg::NETWORK_WIDTH,
  parameter int INDEX_WIDTH   = serial_index_sorter_pkg::INDEX_WIDTH
) ();

  logic                     flush;
  logic                     in_valid;
  logic                     in_ready;
  logic [NETWORK_WIDTH-1:0] in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [NETWORK_WIDTH-1:0] out_data;
  logic [INDEX_WIDTH-1:0]   out_index;
  logic                     out_last;
  logic                     busy;

  modport master (
    output flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data,
    input  out_index, out_last, busy
  );

  modport slave (
    input  flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data,
    output out_index, out_last, busy
  );

endinterface

// File: rtl/serial_index_sorter_compare_swap.sv
// Compare-exchange cell: a_i/b_i in, ordered pair lo_o/hi_o out.
// Equal data never swaps, which keeps the network stable.
module serial_index_sorter_compare_swap
  import serial_index_sorter_pkg::*;
#(
  parameter bit  ASCENDING = 1'b1,
  parameter type entry_t   = sort_entry_t
) (
  input  entry_t a_i,
  input  entry_t b_i,
  output entry_t lo_o,
  output entry_t hi_o
);

  logic swap;

  assign swap = ASCENDING ? (a_i.data > b_i.data)
                          : (a_i.data < b_i.data);
  assign lo_o = swap ? b_i : a_i;
  assign hi_o = swap ? a_i : b_i;

endmodule

// File: rtl/serial_index_sorter.sv
// Serial odd-even transposition sorter: clk, rst_n, bus (slave).
// Loads a frame, sorts one phase per clock, drains {data, index}.
module serial_index_sorter #(
  parameter int NUM_ELEMENTS  = 32,
  parameter int NETWORK_WIDTH = serial_index_sorter_pkg::NETWORK_WIDTH,
  parameter int INDEX_WIDTH   = serial_index_sorter_pkg::INDEX_WIDTH,
  parameter bit ASCENDING     = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_index_sorter_if.slave bus
);
  import serial_index_sorter_pkg::*;

  typedef struct packed {
    logic [NETWORK_WIDTH-1:0] data;
    logic [INDEX_WIDTH-1:0]   index;
  } entry_t;

  localparam int HALF = NUM_ELEMENTS / 2;
  localparam logic [INDEX_WIDTH-1:0] LAST =
    INDEX_WIDTH'(NUM_ELEMENTS - 1);

  sorter_state_t            state_q, state_d;
  logic [INDEX_WIDTH-1:0]   wr_cnt_q, wr_cnt_d;
  logic [INDEX_WIDTH-1:0]   pass_cnt_q, pass_cnt_d;
  logic [INDEX_WIDTH-1:0]   rd_cnt_q, rd_cnt_d;
  logic [INDEX_WIDTH-1:0]   rd_nxt;
  logic [NETWORK_WIDTH-1:0] out_data_q, out_data_d;
  logic [INDEX_WIDTH-1:0]   out_index_q, out_index_d;
  logic                     odd_phase;

  entry_t buf_q [NUM_ELEMENTS];
  entry_t buf_d [NUM_ELEMENTS];
  entry_t net   [NUM_ELEMENTS];
  entry_t cs_a  [HALF];
  entry_t cs_b  [HALF];
  entry_t cs_lo [HALF];
  entry_t cs_hi [HALF];

  assign odd_phase = pass_cnt_q[0];

  // Cell k serves (2k,2k+1) on even phases and (2k+1,2k+2) on odd
  // ones; the last cell has no odd pair and its result is ignored.
  for (genvar k = 0; k < HALF; k++) begin : g_cs
    assign cs_a[k] = odd_phase ? buf_q[2*k+1] : buf_q[2*k];
    assign cs_b[k] = odd_phase ? buf_q[(2*k+2) % NUM_ELEMENTS]
                               : buf_q[2*k+1];
    serial_index_sorter_compare_swap #(
      .ASCENDING (ASCENDING),
      .entry_t   (entry_t)
    ) u_cs (
      .a_i  (cs_a[k]),
      .b_i  (cs_b[k]),
      .lo_o (cs_lo[k]),
      .hi_o (cs_hi[k])
    );
  end

  // Route cell outputs back to slots; the end slots pass through
  // untouched on odd phases.
  for (genvar i = 0; i < NUM_ELEMENTS; i++) begin : g_net
    if (i % 2 == 0) begin : g_even
      if (i == 0) begin : g_first
        assign net[i] = odd_phase ? buf_q[i] : cs_lo[i/2];
      end else begin : g_mid
        assign net[i] = odd_phase ? cs_hi[i/2-1] : cs_lo[i/2];
      end
    end else begin : g_odd
      if (i == NUM_ELEMENTS - 1) begin : g_end
        assign net[i] = odd_phase ? buf_q[i] : cs_hi[i/2];
      end else begin : g_mid
        assign net[i] = odd_phase ? cs_lo[i/2] : cs_hi[i/2];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    wr_cnt_d    = wr_cnt_q;
    pass_cnt_d  = pass_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    out_data_d  = out_data_q;
    out_index_d = out_index_q;
    buf_d       = buf_q;
    rd_nxt      = rd_cnt_q + 1'b1;
    unique case (state_q)
      S_LOAD: begin
        if (bus.in_valid) begin
          buf_d[wr_cnt_q] = '{data: bus.in_data, index: wr_cnt_q};
          if (wr_cnt_q == LAST) begin
            wr_cnt_d   = '0;
            pass_cnt_d = '0;
            state_d    = S_SORT;
          end else begin
            wr_cnt_d = wr_cnt_q + 1'b1;
          end
        end
      end
      S_SORT: begin
        buf_d = net;
        if (pass_cnt_q == LAST) begin
          pass_cnt_d  = '0;
          rd_cnt_d    = '0;
          out_data_d  = net[0].data;
          out_index_d = net[0].index;
          state_d     = S_DRAIN;
        end else begin
          pass_cnt_d = pass_cnt_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (bus.out_ready) begin
          if (rd_cnt_q == LAST) begin
            rd_cnt_d = '0;
            state_d  = S_LOAD;
          end else begin
            rd_cnt_d    = rd_nxt;
            out_data_d  = buf_q[rd_nxt].data;
            out_index_d = buf_q[rd_nxt].index;
          end
        end
      end
      default: state_d = S_LOAD;
    endcase
    if (bus.flush) begin
      state_d    = S_LOAD;
      wr_cnt_d   = '0;
      pass_cnt_d = '0;
      rd_cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_LOAD;
      wr_cnt_q    <= '0;
      pass_cnt_q  <= '0;
      rd_cnt_q    <= '0;
      out_data_q  <= '0;
      out_index_q <= '0;
    end else begin
      state_q     <= state_d;
      wr_cnt_q    <= wr_cnt_d;
      pass_cnt_q  <= pass_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      out_data_q  <= out_data_d;
      out_index_q <= out_index_d;
    end
  end

  // Sample storage keeps its contents across reset.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  assign bus.in_ready  = (state_q == S_LOAD);
  assign bus.out_valid = (state_q == S_DRAIN);
  assign bus.busy      = (state_q != S_LOAD);
  assign bus.out_last  = (state_q == S_DRAIN) && (rd_cnt_q == LAST);
  assign bus.out_data  = out_data_q;
  assign bus.out_index = out_index_q;

endmodule

// File: tb/tb_serial_index_sorter.sv
// Bench for serial_index_sorter: N=8 ascending and descending DUTs
// driven in lockstep with a scoreboard, plus an N=4 DUT.
module tb_serial_index_sorter;

  logic clk;
  logic rst_n;
  logic flush;
  logic in_valid;
  logic [7:0] in_data;
  logic out_ready;

  int checks;
  int failures;

  serial_index_sorter_if #(.NETWORK_WIDTH(8), .INDEX_WIDTH(3)) if_a ();
  serial_index_sorter_if #(.NETWORK_WIDTH(8), .INDEX_WIDTH(3)) if_d ();
  serial_index_sorter_if #(.NETWORK_WIDTH(8), .INDEX_WIDTH(2)) if_4 ();

  assign if_a.flush     = flush;
  assign if_a.in_valid  = in_valid;
  assign if_a.in_data   = in_data;
  assign if_a.out_ready = out_ready;
  assign if_d.flush     = flush;
  assign if_d.in_valid  = in_valid;
  assign if_d.in_data   = in_data;
  assign if_d.out_ready = out_ready;

  serial_index_sorter #(
    .NUM_ELEMENTS(8), .NETWORK_WIDTH(8),
    .INDEX_WIDTH(3), .ASCENDING(1'b1)
  ) dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));

  serial_index_sorter #(
    .NUM_ELEMENTS(8), .NETWORK_WIDTH(8),
    .INDEX_WIDTH(3), .ASCENDING(1'b0)
  ) dut_d (.clk(clk), .rst_n(rst_n), .bus(if_d));

  serial_index_sorter #(
    .NUM_ELEMENTS(4), .NETWORK_WIDTH(8),
    .INDEX_WIDTH(2), .ASCENDING(1'b1)
  ) dut_4 (.clk(clk), .rst_n(rst_n), .bus(if_4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0][7:0] din;
    logic [7:0][7:0] edat;
    logic [7:0][2:0] eidx;
    logic            stall;
    logic            garbage;
  } vec_t;

  typedef struct packed {
    logic [7:0] data;
    logic [2:0] index;
    logic       last;
  } exp_t;

  vec_t tab [4];
  exp_t exp_a [$];
  exp_t exp_d [$];

  logic [7:0] cur  [8];
  logic [7:0] ea_d [8];
  logic [2:0] ea_i [8];
  logic [7:0] md   [8];
  logic [2:0] mi   [8];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Stable reference sort of cur[] into md/mi.
  task automatic model(input bit asc);
    logic [7:0] td;
    logic [2:0] ti;
    for (int i = 0; i < 8; i++) begin
      md[i] = cur[i];
      mi[i] = 3'(i);
    end
    for (int i = 1; i < 8; i++) begin
      for (int j = i; j > 0; j--) begin
        if (asc ? (md[j-1] > md[j]) : (md[j-1] < md[j])) begin
          td = md[j]; md[j] = md[j-1]; md[j-1] = td;
          ti = mi[j]; mi[j] = mi[j-1]; mi[j-1] = ti;
        end else begin
          break;
        end
      end
    end
  endtask

  // Scoreboard monitor, sampled on the falling edge.
  logic       held;
  logic [7:0] h_data;
  logic [2:0] h_idx;
  logic       h_last;
  exp_t       e;

  always @(negedge clk) begin
    if (!rst_n) begin
      held = 1'b0;
    end else begin
      if (held) begin
        chk("hold_data", if_a.out_data, h_data);
        chk("hold_index", if_a.out_index, h_idx);
        chk("hold_last", if_a.out_last, h_last);
      end
      held   = if_a.out_valid && !out_ready;
      h_data = if_a.out_data;
      h_idx  = if_a.out_index;
      h_last = if_a.out_last;
      if (if_a.out_valid && out_ready) begin
        if (exp_a.size() == 0) begin
          chk("unexpected_out_a", 1, 0);
        end else begin
          e = exp_a.pop_front();
          chk("asc_data", if_a.out_data, e.data);
          chk("asc_index", if_a.out_index, e.index);
          chk("asc_last", if_a.out_last, e.last);
        end
      end
      if (if_d.out_valid && out_ready) begin
        if (exp_d.size() == 0) begin
          chk("unexpected_out_d", 1, 0);
        end else begin
          e = exp_d.pop_front();
          chk("desc_data", if_d.out_data, e.data);
          chk("desc_index", if_d.out_index, e.index);
          chk("desc_last", if_d.out_last, e.last);
        end
      end
    end
  end

  task automatic push_frame();
    model(1'b0);
    for (int i = 0; i < 8; i++) begin
      exp_a.push_back('{ea_d[i], ea_i[i], (i == 7)});
      exp_d.push_back('{md[i], mi[i], (i == 7)});
    end
  endtask

  task automatic load8();
    int b;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = cur[i];
      b = 0;
      while (!if_a.in_ready && b < 100) begin
        @(posedge clk); #1;
        b++;
      end
      chk("load_ready", if_a.in_ready, 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input bit garb, output int lat);
    lat = 0;
    do begin
      if (garb) begin
        in_valid = 1'b1;
        in_data  = 8'($urandom);
      end
      @(posedge clk); #1;
      lat++;
    end while (!if_a.out_valid && lat < 100);
  endtask

  task automatic drain(input bit stall, input bit garb);
    int b;
    b = 0;
    while (exp_a.size() != 0 && b < 1000) begin
      out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (garb) begin
        if (if_a.out_last) in_valid = 1'b0;
        else begin
          in_valid = 1'b1;
          in_data  = 8'($urandom);
        end
      end
      @(posedge clk); #1;
      b++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("drain_left", exp_a.size() + exp_d.size(), 0);
    chk("reload_in_ready", if_a.in_ready, 1);
    chk("reload_out_valid", if_a.out_valid, 0);
  endtask

  task automatic run_frame(input bit stall, input bit garb);
    int lat;
    push_frame();
    load8();
    wait_valid(garb, lat);
    chk("latency", lat, 8);
    drain(stall, garb);
  endtask

  task automatic use_row(input int r);
    for (int i = 0; i < 8; i++) begin
      cur[i]  = tab[r].din[i];
      ea_d[i] = tab[r].edat[i];
      ea_i[i] = tab[r].eidx[i];
    end
  endtask

  task automatic use_random();
    for (int i = 0; i < 8; i++) cur[i] = 8'($urandom_range(0, 15));
    model(1'b1);
    for (int i = 0; i < 8; i++) begin
      ea_d[i] = md[i];
      ea_i[i] = mi[i];
    end
  endtask

  logic [7:0] v4 [4];
  logic [7:0] d4 [4];
  logic [1:0] i4 [4];

  initial begin
    int lat;
    int seen;
    int b;
    checks = 0; failures = 0;
    rst_n = 1'b0; flush = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    if_4.flush = 1'b0; if_4.in_valid = 1'b0;
    if_4.in_data = '0; if_4.out_ready = 1'b0;

    for (int i = 0; i < 8; i++) begin
      tab[0].din[i]  = 8'(7 - i);
      tab[0].edat[i] = 8'(i);
      tab[0].eidx[i] = 3'(7 - i);
      tab[1].din[i]  = 8'd5;
      tab[1].edat[i] = 8'd5;
      tab[1].eidx[i] = 3'(i);
      tab[3].din[i]  = 8'(i);
      tab[3].edat[i] = 8'(i);
      tab[3].eidx[i] = 3'(i);
    end
    tab[0].stall = 1'b0; tab[0].garbage = 1'b1;
    tab[1].stall = 1'b1; tab[1].garbage = 1'b0;
    tab[3].stall = 1'b0; tab[3].garbage = 1'b0;
    tab[2].din  = {8'd0, 8'd35, 8'd200, 8'd10,
                   8'd35, 8'd95, 8'd35, 8'd92};
    tab[2].edat = {8'd200, 8'd95, 8'd92, 8'd35,
                   8'd35, 8'd35, 8'd10, 8'd0};
    tab[2].eidx = {3'd5, 3'd2, 3'd0, 3'd6,
                   3'd3, 3'd1, 3'd4, 3'd7};
    tab[2].stall = 1'b1; tab[2].garbage = 1'b0;

    #12;
    chk("rst_in_ready", if_a.in_ready, 1);
    chk("rst_out_valid", if_a.out_valid, 0);
    chk("rst_out_last", if_a.out_last, 0);
    chk("rst_busy", if_a.busy, 0);
    chk("rst_out_data", if_a.out_data, 0);
    chk("rst_out_index", if_a.out_index, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int r = 0; r < 4; r++) begin
      use_row(r);
      run_frame(tab[r].stall, tab[r].garbage);
    end
    for (int n = 0; n < 3; n++) begin
      use_random();
      run_frame(1'b1, 1'b0);
    end

    // Flush at sort pass 3: nothing may come out.
    use_random();
    load8();
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("pre_flush_busy", if_a.busy, 1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_busy", if_a.busy, 0);
    chk("flush_in_ready", if_a.in_ready, 1);
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (if_a.out_valid) seen++;
    end
    chk("flush_no_output", seen, 0);
    use_row(0);
    run_frame(1'b0, 1'b0);

    // Flush in LOAD discards the partial frame.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(250 + i);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    use_random();
    run_frame(1'b1, 1'b0);

    // Asynchronous reset in the middle of DRAIN.
    use_random();
    push_frame();
    load8();
    wait_valid(1'b0, lat);
    chk("pre_rst_latency", lat, 8);
    out_ready = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", if_a.out_valid, 0);
    chk("arst_in_ready", if_a.in_ready, 1);
    chk("arst_busy", if_a.busy, 0);
    exp_a.delete();
    exp_d.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    use_random();
    run_frame(1'b1, 1'b0);

    // N=4 instance, direct comparison.
    v4[0] = 8'd92; v4[1] = 8'd35; v4[2] = 8'd95; v4[3] = 8'd35;
    d4[0] = 8'd35; d4[1] = 8'd35; d4[2] = 8'd92; d4[3] = 8'd95;
    i4[0] = 2'd1;  i4[1] = 2'd3;  i4[2] = 2'd0;  i4[3] = 2'd2;
    for (int i = 0; i < 4; i++) begin
      if_4.in_valid = 1'b1;
      if_4.in_data  = v4[i];
      b = 0;
      while (!if_4.in_ready && b < 100) begin
        @(posedge clk); #1;
        b++;
      end
      chk("n4_load_ready", if_4.in_ready, 1);
      @(posedge clk); #1;
    end
    if_4.in_valid = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!if_4.out_valid && lat < 100);
    chk("n4_latency", lat, 4);
    if_4.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("n4_valid", if_4.out_valid, 1);
      chk("n4_data", if_4.out_data, d4[i]);
      chk("n4_index", if_4.out_index, i4[i]);
      chk("n4_last", if_4.out_last, (i == 3));
      @(posedge clk); #1;
    end
    if_4.out_ready = 1'b0;
    chk("n4_done_valid", if_4.out_valid, 0);
    chk("n4_done_ready", if_4.in_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    failures++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
